// File: rtl/seq_pkg.sv
// Shared types, widths and output decode for the micro-op sequencer.
// Contents: instr_type_t / seq_state_t enums, the latched-instruction and
// strobe-bundle structs, ALU select constants, and seq_decode(), which maps
// a sequencer step plus the latched instruction to its datapath strobes.
package seq_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RIDX_W    = 5;
    localparam int unsigned ALU_SEL_W = 5;
    localparam int unsigned RETIRE_W  = 32;

    localparam logic [ALU_SEL_W-1:0] ALU_SEL_AND = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = ALU_SEL_W'(12);

    typedef enum logic [1:0] {
        ITYPE_NONE = 2'd0,
        ITYPE_I    = 2'd1,
        ITYPE_R    = 2'd2,
        ITYPE_U    = 2'd3
    } instr_type_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A    = 3'd1,
        B    = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } seq_state_t;

    // Instruction fields captured at the accept handshake
    typedef struct packed {
        instr_type_t           itype;
        logic [RIDX_W-1:0]     rs1;
        logic [RIDX_W-1:0]     rs2;
        logic [RIDX_W-1:0]     rd;
        logic [XLEN-1:0]       imm;
        logic [ALU_SEL_W-1:0]  alu_sel;
    } instr_t;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic [ALU_SEL_W-1:0]  alu_sel;
        logic                  store_1;
        logic                  store_2;
        logic                  broadcast;
        logic [RIDX_W-1:0]     reg_idx;
        logic                  reg_rd;
        logic                  reg_wr;
        logic [XLEN-1:0]       imm;
        logic                  imm_en;
        logic                  done;
        logic                  illegal;
    } seq_out_t;

    // Strobes for a given step; exactly one bus driver is enabled per step
    function automatic seq_out_t seq_decode(input seq_state_t st, input instr_t ins);
        seq_out_t             o;
        logic [ALU_SEL_W-1:0] eff_sel;
        o = '0;
        // U-type feeds imm into both operands, so AND reproduces imm
        eff_sel = (ins.itype == ITYPE_U) ? ALU_SEL_AND : ins.alu_sel;
        case (st)
            A: begin
                o.alu_sel = eff_sel;
                o.store_1 = 1'b1;
                if (ins.itype == ITYPE_U) begin
                    o.imm_en = 1'b1;
                    o.imm    = ins.imm;
                end else begin
                    o.reg_idx = ins.rs1;
                    o.reg_rd  = 1'b1;
                end
            end
            B: begin
                o.alu_sel = eff_sel;
                o.store_2 = 1'b1;
                if (ins.itype == ITYPE_R) begin
                    o.reg_idx = ins.rs2;
                    o.reg_rd  = 1'b1;
                end else begin
                    o.imm_en = 1'b1;
                    o.imm    = ins.imm;
                end
            end
            WB: begin
                o.alu_sel   = eff_sel;
                o.broadcast = 1'b1;
                o.done      = 1'b1;
                o.reg_idx   = ins.rd;
                o.reg_wr    = (ins.rd != '0);
            end
            ERR: begin
                o.illegal = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle micro-op sequencer for the shared operand bus.
// Accepts one decoded instruction per valid/ready handshake and steps it
// through READ_A -> READ_B -> WRITEBACK, driving register-file, immediate
// and ALU strobes. Type-0 instructions take a single ERR step (illegal pulse).
// Ports:
//   clk, reset (async, active-high)
//   instr_valid/instr_ready handshake, instr_type, rs1, rs2, rd, imm_in, alu_sel_in
//   stall: hold the current A/B/WB step with all strobes dropped
//   alu_function_sel, alu_store_1/2, alu_broadcast, register_index,
//   register_read_enable, register_write_enable, imm, imm_EN: datapath controls
//   busy, done, illegal: status
// Optional: define SEQ_RETIRE_COUNT_EN to add retired_count (completed writebacks).
module instr_sequencer
    import seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [1:0]            instr_type,
    input  logic [RIDX_W-1:0]     rs1,
    input  logic [RIDX_W-1:0]     rs2,
    input  logic [RIDX_W-1:0]     rd,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [ALU_SEL_W-1:0]  alu_sel_in,
    input  logic                  stall,
    output logic [ALU_SEL_W-1:0]  alu_function_sel,
    output logic                  alu_store_1,
    output logic                  alu_store_2,
    output logic                  alu_broadcast,
    output logic [RIDX_W-1:0]     register_index,
    output logic                  register_read_enable,
    output logic                  register_write_enable,
    output logic [XLEN-1:0]       imm,
    output logic                  imm_EN,
    output logic                  busy,
    output logic                  done,
`ifdef SEQ_RETIRE_COUNT_EN
    output logic [RETIRE_W-1:0]   retired_count,
`endif
    output logic                  illegal
);

    seq_state_t state_q, state_d;
    instr_t     instr_q, instr_d;
    seq_out_t   out_q;
    logic       accept;
    logic       hold;

    assign instr_ready = (state_q == IDLE) && !stall;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state_q != IDLE);
    // ERR is deliberately excluded: the illegal pulse ignores stall
    assign hold        = stall && ((state_q == A) || (state_q == B) || (state_q == WB));

    // Next state and instruction latch
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d = '{itype:   instr_type_t'(instr_type),
                                rs1:     rs1,
                                rs2:     rs2,
                                rd:      rd,
                                imm:     imm_in,
                                alu_sel: alu_sel_in};
                    state_d = (instr_type_t'(instr_type) == ITYPE_NONE) ? ERR : A;
                end
            end
            A:       if (!stall) state_d = B;
            B:       if (!stall) state_d = WB;
            WB:      if (!stall) state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched fields, and strobes pre-decoded for the step being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            out_q   <= seq_decode(state_d, instr_d);
        end
    end

    // A stalled step shows no strobes but keeps its ALU function visible
    assign alu_function_sel      = out_q.alu_sel;
    assign alu_store_1           = out_q.store_1   && !hold;
    assign alu_store_2           = out_q.store_2   && !hold;
    assign alu_broadcast         = out_q.broadcast && !hold;
    assign register_index        = hold ? '0 : out_q.reg_idx;
    assign register_read_enable  = out_q.reg_rd    && !hold;
    assign register_write_enable = out_q.reg_wr    && !hold;
    assign imm                   = hold ? '0 : out_q.imm;
    assign imm_EN                = out_q.imm_en    && !hold;
    assign done                  = out_q.done      && !hold;
    assign illegal               = out_q.illegal;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] retire_q;

    // Counts writebacks that actually execute; wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if ((state_q == WB) && !stall) begin
            retire_q <= retire_q + RETIRE_W'(1);
        end
    end

    assign retired_count = retire_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed vector table, hand-written
// stall/illegal/reset sequences, then random traffic against a step-queue model.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_type;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_in;
    logic [4:0]  alu_sel_in;
    logic        stall;
    logic [4:0]  alu_function_sel;
    logic        alu_store_1, alu_store_2, alu_broadcast;
    logic [4:0]  register_index;
    logic        register_read_enable, register_write_enable;
    logic [31:0] imm;
    logic        imm_EN;
    logic        busy, done, illegal;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    instr_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .instr_type            (instr_type),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .rd                    (rd),
        .imm_in                (imm_in),
        .alu_sel_in            (alu_sel_in),
        .stall                 (stall),
        .alu_function_sel      (alu_function_sel),
        .alu_store_1           (alu_store_1),
        .alu_store_2           (alu_store_2),
        .alu_broadcast         (alu_broadcast),
        .register_index        (register_index),
        .register_read_enable  (register_read_enable),
        .register_write_enable (register_write_enable),
        .imm                   (imm),
        .imm_EN                (imm_EN),
        .busy                  (busy),
        .done                  (done),
`ifdef SEQ_RETIRE_COUNT_EN
        .retired_count         (retired_count),
`endif
        .illegal               (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  sel;
        logic        s1;
        logic        s2;
        logic        bc;
        logic [4:0]  idx;
        logic        rd_en;
        logic        wr_en;
        logic        imm_en;
        logic [31:0] imm;
        logic        done;
        logic        illegal;
        logic        busy;
        logic        ready;
    } obs_t;

    typedef struct {
        int          itype;
        int          rs1;
        int          rs2;
        int          rd;
        logic [31:0] imm;
        int          sel;
        obs_t        exp_a;
        obs_t        exp_b;
        obs_t        exp_wb;
    } vec_t;

    int          checks;
    int          errors;
    logic [31:0] exp_retire;
    obs_t        model_q[$];
    vec_t        vt[5];

    // Expected outputs for an in-flight step (busy, not ready)
    function automatic obs_t ob(input int sel, input int s1, input int s2, input int bc,
                                input int idx, input int rde, input int wre, input int ie,
                                input logic [31:0] im, input int dn);
        obs_t o;
        o        = '0;
        o.sel    = 5'(sel);
        o.s1     = 1'(s1);
        o.s2     = 1'(s2);
        o.bc     = 1'(bc);
        o.idx    = 5'(idx);
        o.rd_en  = 1'(rde);
        o.wr_en  = 1'(wre);
        o.imm_en = 1'(ie);
        o.imm    = im;
        o.done   = 1'(dn);
        o.busy   = 1'b1;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic rdy);
        obs_t o;
        o       = '0;
        o.ready = rdy;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.sel     = alu_function_sel;
        o.s1      = alu_store_1;
        o.s2      = alu_store_2;
        o.bc      = alu_broadcast;
        o.idx     = register_index;
        o.rd_en   = register_read_enable;
        o.wr_en   = register_write_enable;
        o.imm_en  = imm_EN;
        o.imm     = imm;
        o.done    = done;
        o.illegal = illegal;
        o.busy    = busy;
        o.ready   = instr_ready;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        #1;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (sel,s1,s2,bc,idx,rd,wr,ie,imm,done,ill,busy,rdy)",
                     name, a, e);
        end
    endtask

`ifdef SEQ_RETIRE_COUNT_EN
    task automatic check_cnt(input string name);
        checks++;
        if (retired_count !== exp_retire) begin
            errors++;
            $display("FAIL %s: retired_count got %0d expected %0d", name, retired_count, exp_retire);
        end
    endtask
`endif

    task automatic drive(input int v, input int t, input int a, input int b, input int d,
                         input logic [31:0] im, input int s, input int st);
        instr_valid = 1'(v);
        instr_type  = 2'(t);
        rs1         = 5'(a);
        rs2         = 5'(b);
        rd          = 5'(d);
        imm_in      = im;
        alu_sel_in  = 5'(s);
        stall       = 1'(st);
    endtask

    // Inputs are don't-care once accepted; scramble them
    task automatic scramble(input int st);
        drive(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              $urandom, int'($urandom_range(0, 31)), st);
    endtask

    // Reference: an accepted instruction becomes a list of per-cycle bus steps
    function automatic void push_instr(input int t, input int a, input int b, input int d,
                                       input logic [31:0] im, input int s);
        int  sel_eff;
        bit  a_reg, b_reg;
        if (t == 0) begin
            obs_t e;
            e         = '0;
            e.illegal = 1'b1;
            e.busy    = 1'b1;
            model_q.push_back(e);
            return;
        end
        sel_eff = (t == 3) ? 2 : s;
        a_reg   = (t != 3);
        b_reg   = (t == 2);
        model_q.push_back(a_reg ? ob(sel_eff, 1, 0, 0, a, 1, 0, 0, 32'h0, 0)
                                : ob(sel_eff, 1, 0, 0, 0, 0, 0, 1, im, 0));
        model_q.push_back(b_reg ? ob(sel_eff, 0, 1, 0, b, 1, 0, 0, 32'h0, 0)
                                : ob(sel_eff, 0, 1, 0, 0, 0, 0, 1, im, 0));
        model_q.push_back(ob(sel_eff, 0, 0, 1, d, 0, (d != 0) ? 1 : 0, 0, 32'h0, 1));
    endfunction

    initial begin
        obs_t e;
        checks     = 0;
        errors     = 0;
        exp_retire = 32'd0;

        vt[0] = '{2, 3, 4, 5, 32'hDEAD_BEEF, 12,
                  ob(12, 1, 0, 0, 3, 1, 0, 0, 32'h0, 0),
                  ob(12, 0, 1, 0, 4, 1, 0, 0, 32'h0, 0),
                  ob(12, 0, 0, 1, 5, 0, 1, 0, 32'h0, 1)};
        vt[1] = '{1, 2, 9, 7, 32'h0000_0123, 12,
                  ob(12, 1, 0, 0, 2, 1, 0, 0, 32'h0, 0),
                  ob(12, 0, 1, 0, 0, 0, 0, 1, 32'h0000_0123, 0),
                  ob(12, 0, 0, 1, 7, 0, 1, 0, 32'h0, 1)};
        vt[2] = '{3, 1, 1, 9, 32'h1234_5000, 12,
                  ob(2, 1, 0, 0, 0, 0, 0, 1, 32'h1234_5000, 0),
                  ob(2, 0, 1, 0, 0, 0, 0, 1, 32'h1234_5000, 0),
                  ob(2, 0, 0, 1, 9, 0, 1, 0, 32'h0, 1)};
        vt[3] = '{2, 1, 2, 0, 32'h0, 7,
                  ob(7, 1, 0, 0, 1, 1, 0, 0, 32'h0, 0),
                  ob(7, 0, 1, 0, 2, 1, 0, 0, 32'h0, 0),
                  ob(7, 0, 0, 1, 0, 0, 0, 0, 32'h0, 1)};
        vt[4] = '{1, 31, 0, 31, 32'hFFFF_FFFF, 31,
                  ob(31, 1, 0, 0, 31, 1, 0, 0, 32'h0, 0),
                  ob(31, 0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0),
                  ob(31, 0, 0, 1, 31, 0, 1, 0, 32'h0, 1)};

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        tick();
        check_obs("reset", idle_obs(1'b1));
`ifdef SEQ_RETIRE_COUNT_EN
        check_cnt("reset_cnt");
`endif
        reset = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 5; i++) begin
            drive(1, vt[i].itype, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].imm, vt[i].sel, 0);
            check_obs($sformatf("vec%0d_accept", i), idle_obs(1'b1));
            tick();
            scramble(0);
            check_obs($sformatf("vec%0d_A", i), vt[i].exp_a);
            tick();
            check_obs($sformatf("vec%0d_B", i), vt[i].exp_b);
            tick();
            check_obs($sformatf("vec%0d_WB", i), vt[i].exp_wb);
            tick();
            exp_retire++;
            instr_valid = 1'b0;
            check_obs($sformatf("vec%0d_ready", i), idle_obs(1'b1));
        end
`ifdef SEQ_RETIRE_COUNT_EN
        check_cnt("table_cnt");
`endif

        // Illegal: pulse at cycle 1 even under stall, ready at cycle 2
        tick();
        drive(1, 0, 1, 2, 3, 32'h55, 4, 0);
        check_obs("ill_accept", idle_obs(1'b1));
        tick();
        drive(1, 2, 1, 2, 3, 32'h55, 4, 1);
        e         = '0;
        e.illegal = 1'b1;
        e.busy    = 1'b1;
        check_obs("ill_pulse", e);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        check_obs("ill_ready", idle_obs(1'b1));
`ifdef SEQ_RETIRE_COUNT_EN
        check_cnt("ill_cnt");
`endif

        // Stall in IDLE blocks the handshake
        tick();
        drive(1, 2, 1, 2, 3, 32'h0, 12, 1);
        check_obs("idle_stall", idle_obs(1'b0));
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        check_obs("idle_stall_noaccept", idle_obs(1'b1));

        // Stall two cycles in B and one in WB
        tick();
        drive(1, 2, 10, 11, 12, 32'h0, 12, 0);
        check_obs("st_accept", idle_obs(1'b1));
        tick();
        scramble(0);
        check_obs("st_A", ob(12, 1, 0, 0, 10, 1, 0, 0, 32'h0, 0));
        tick();
        scramble(1);
        check_obs("st_B_hold1", ob(12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        tick();
        scramble(1);
        check_obs("st_B_hold2", ob(12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        tick();
        scramble(0);
        check_obs("st_B", ob(12, 0, 1, 0, 11, 1, 0, 0, 32'h0, 0));
        tick();
        scramble(1);
        check_obs("st_WB_hold", ob(12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
`ifdef SEQ_RETIRE_COUNT_EN
        tick();
        scramble(0);
        check_obs("st_WB", ob(12, 0, 0, 1, 12, 0, 1, 0, 32'h0, 1));
        check_cnt("st_cnt_before");
`else
        tick();
        scramble(0);
        check_obs("st_WB", ob(12, 0, 0, 1, 12, 0, 1, 0, 32'h0, 1));
`endif
        tick();
        exp_retire++;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        check_obs("st_ready", idle_obs(1'b1));
`ifdef SEQ_RETIRE_COUNT_EN
        check_cnt("st_cnt_after");
`endif

        // Reset during B aborts with no later write strobe
        tick();
        drive(1, 3, 0, 0, 9, 32'h1234_5000, 12, 0);
        check_obs("rst_accept", idle_obs(1'b1));
        tick();
        scramble(0);
        check_obs("rst_A", ob(2, 1, 0, 0, 0, 0, 0, 1, 32'h1234_5000, 0));
        tick();
        reset = 1'b1;
        exp_retire = 32'd0;
        check_obs("rst_mid", idle_obs(1'b1));
`ifdef SEQ_RETIRE_COUNT_EN
        check_cnt("rst_cnt");
`endif
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_obs($sformatf("rst_after%0d", k), idle_obs(1'b1));
        end

        // Random traffic against the step-queue model
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            tick();
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0);
            if (model_q.size() == 0) begin
                e = idle_obs(!stall);
            end else if (stall && !model_q[0].illegal) begin
                e = ob(int'(model_q[0].sel), 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
            end else begin
                e = model_q[0];
            end
            check_obs($sformatf("rand%0d", c), e);
`ifdef SEQ_RETIRE_COUNT_EN
            check_cnt($sformatf("rand_cnt%0d", c));
`endif
            if (model_q.size() != 0) begin
                if (!stall || model_q[0].illegal) begin
                    if (model_q[0].done) exp_retire++;
                    void'(model_q.pop_front());
                end
            end else if (instr_valid && !stall) begin
                push_instr(int'(instr_type), int'(rs1), int'(rs2), int'(rd), imm_in, int'(alu_sel_in));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
